// File: rtl/grf_wb_arbiter.sv
// Round-robin write-back arbiter for the single GRF write port, plus a
// per-register outstanding-write scoreboard feeding decode RAW stall checks.

module grf_sb_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt,
  output logic       uflow
);
  // inc is already gated by the saturation stall, so it never fires at 3
  assign uflow = dec & ~inc & (cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (inc & ~dec)                 cnt <= cnt + 2'd1;
    else if (dec & ~inc & (cnt != 2'd0)) cnt <= cnt - 2'd1;
  end
endmodule

module grf_wb_arbiter #(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [14:0]       req_addr,
  input  logic [3*DW-1:0]   req_data,
  input  logic [3*DW-1:0]   req_pc,
  input  logic              iss_valid,
  input  logic [4:0]        iss_addr,
  output logic              iss_stall,
  input  logic [4:0]        chk_a1,
  input  logic [4:0]        chk_a2,
  output logic              busy_a1,
  output logic              busy_a2,
  output logic              RegWr,
  output logic [4:0]        A3,
  output logic [DW-1:0]     res,
  output logic [DW-1:0]     WPC,
  output logic              sb_err
);
  localparam int NSRC = 3;
  localparam int NREG = 32;

  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } wb_req_t;

  wb_req_t [NSRC-1:0] req;
  wb_req_t            win;
  logic [1:0]         ptr;
  logic [1:0]         gidx;
  logic               xfer;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_req
    assign req[gi] = '{addr: req_addr[5*gi +: 5],
                       data: req_data[DW*gi +: DW],
                       pc:   req_pc[DW*gi +: DW]};
  end

  // Search ptr, ptr+1, ptr+2 (mod 3); the first valid source wins.
  always_comb begin
    int s;
    xfer = 1'b0;
    gidx = 2'd0;
    s    = 0;
    for (int k = 0; k < NSRC; k++) begin
      s = int'(ptr) + k;
      if (s >= NSRC) s = s - NSRC;
      if (!xfer && req_valid[s]) begin
        xfer = 1'b1;
        gidx = 2'(s);
      end
    end
  end

  assign req_ready = xfer ? (3'b001 << gidx) : 3'b000;
  assign win       = req[gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= 2'd0;
      RegWr <= 1'b0;
      A3    <= '0;
      res   <= '0;
      WPC   <= '0;
    end else if (xfer) begin
      ptr   <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
      RegWr <= (win.addr != 5'd0);
      A3    <= win.addr;
      res   <= win.data;
      WPC   <= win.pc;
    end else begin
      RegWr <= 1'b0;
    end
  end

  logic [NREG-1:0][1:0] cnt;
  logic [NREG-1:0]      inc;
  logic [NREG-1:0]      dec;
  logic [NREG-1:0]      uflow;
  logic                 iss_fire;

  assign iss_stall = iss_valid & (iss_addr != 5'd0) & (cnt[iss_addr] == 2'd3);
  assign iss_fire  = iss_valid & ~iss_stall & (iss_addr != 5'd0);

  // r0 is hardwired and never tracked
  assign cnt[0]   = 2'd0;
  assign inc[0]   = 1'b0;
  assign dec[0]   = 1'b0;
  assign uflow[0] = 1'b0;

  for (genvar gr = 1; gr < NREG; gr++) begin : g_sb
    assign inc[gr] = iss_fire & (iss_addr == 5'(gr));
    assign dec[gr] = xfer & (win.addr == 5'(gr));
    grf_sb_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[gr]),
      .dec   (dec[gr]),
      .cnt   (cnt[gr]),
      .uflow (uflow[gr])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sb_err <= 1'b0;
    else if (|uflow) sb_err <= 1'b1;
  end

  // The RegWr/A3 term covers the cycle between acceptance and the GRF commit.
  assign busy_a1 = (chk_a1 != 5'd0) & ((cnt[chk_a1] != 2'd0) | (RegWr & (A3 == chk_a1)));
  assign busy_a2 = (chk_a2 != 5'd0) & ((cnt[chk_a2] != 2'd0) | (RegWr & (A3 == chk_a2)));
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: a behavioural model checked every cycle
// plus literal expectations along the test-plan scenarios.
module tb_grf_wb_arbiter;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [2:0]      req_valid = '0;
  logic [2:0]      req_ready;
  logic [14:0]     req_addr = '0;
  logic [3*DW-1:0] req_data = '0;
  logic [3*DW-1:0] req_pc = '0;
  logic            iss_valid = 1'b0;
  logic [4:0]      iss_addr = '0;
  logic            iss_stall;
  logic [4:0]      chk_a1 = '0;
  logic [4:0]      chk_a2 = '0;
  logic            busy_a1, busy_a2;
  logic            RegWr;
  logic [4:0]      A3;
  logic [DW-1:0]   res, WPC;
  logic            sb_err;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .busy_a1(busy_a1), .busy_a2(busy_a2),
    .RegWr(RegWr), .A3(A3), .res(res), .WPC(WPC), .sb_err(sb_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr;
  int            m_cnt[32];
  logic          m_rw;
  logic [4:0]    m_a3;
  logic [DW-1:0] m_res, m_wpc;
  logic          m_err;
  int            mg, ma, mw;

  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic logic m_busy(input logic [4:0] r);
    return (r != 0) && ((m_cnt[r] != 0) || (m_rw && m_a3 == r));
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_rw = 0; m_a3 = '0; m_res = '0; m_wpc = '0; m_err = 0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        mg = pick(req_valid, m_ptr);
        ma = int'(iss_addr);
        if (iss_valid && ma != 0 && m_cnt[ma] < 3) m_cnt[ma] = m_cnt[ma] + 1;
        if (mg >= 0) begin
          mw    = int'(req_addr[5*mg +: 5]);
          m_a3  = 5'(mw);
          m_res = req_data[DW*mg +: DW];
          m_wpc = req_pc[DW*mg +: DW];
          m_rw  = (mw != 0);
          m_ptr = (mg + 1) % 3;
          if (mw != 0) begin
            if (m_cnt[mw] > 0) m_cnt[mw] = m_cnt[mw] - 1;
            else m_err = 1;
          end
        end else begin
          m_rw = 0;
        end
      end
    end
  end

  int cg;
  initial begin
    forever begin
      @(negedge clk);
      cg = pick(req_valid, m_ptr);
      check("m_req_ready", req_ready, (cg < 0) ? 64'd0 : 64'(1 << cg));
      check("m_iss_stall", iss_stall, iss_valid && iss_addr != 0 && m_cnt[iss_addr] == 3);
      check("m_busy_a1", busy_a1, m_busy(chk_a1));
      check("m_busy_a2", busy_a2, m_busy(chk_a2));
      check("m_RegWr", RegWr, m_rw);
      check("m_A3", A3, m_a3);
      check("m_res", res, m_res);
      check("m_WPC", WPC, m_wpc);
      check("m_sb_err", sb_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic src(input int i, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    req_addr[5*i +: 5]   = a;
    req_data[DW*i +: DW] = d;
    req_pc[DW*i +: DW]   = pc;
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1'b1; iss_addr = r;
    tick();
    iss_valid = 1'b0;
  endtask

  logic [2:0] exp_rr [6];
  logic [4:0] exp_a3 [6];

  initial begin
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_a3 = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11, 5'd12};
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Mid-stream reset with RegWr=1 and cnt[5]=2
    chk_a1 = 5'd5;
    issue(5); issue(5); issue(4);
    src(0, 5'd4, 32'h44, 32'h400);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    check("pre_rst_regwr", RegWr, 1);
    check("pre_rst_busy5", busy_a1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_regwr", RegWr, 0);
    check("rst_a3", A3, 0);
    check("rst_busy5", busy_a1, 0);
    check("rst_sb_err", sb_err, 0);
    tick();
    rst_n = 1'b1;

    // Round-robin fairness, ptr=0 after reset: first grant goes to ALU
    issue(10); issue(10); issue(11); issue(11); issue(12); issue(12);
    src(0, 5'd10, 32'hA0A0, 32'h100);
    src(1, 5'd11, 32'hB1B1, 32'h200);
    src(2, 5'd12, 32'hC2C2, 32'h300);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_order", req_ready, exp_rr[i]);
      tick();
      check("rr_a3", A3, exp_a3[i]);
    end
    req_valid = 3'b000;
    check("rr_res_last", res, 32'hC2C2);
    check("rr_wpc_last", WPC, 32'h300);

    // $0 write from MEM
    src(1, 5'd0, 32'hDEADBEEF, 32'h240);
    req_valid = 3'b010;
    #1 check("zero_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    check("zero_regwr", RegWr, 0);
    check("zero_res", res, 32'hDEADBEEF);
    check("zero_sb_err", sb_err, 0);

    // Busy window on r7
    chk_a1 = 5'd7;
    issue(7);
    check("busy_issued", busy_a1, 1);
    src(0, 5'd7, 32'h1234, 32'h700);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    check("busy_commit", busy_a1, 1);
    check("busy_a3", A3, 7);
    check("busy_res", res, 32'h1234);
    tick();
    check("busy_clear", busy_a1, 0);

    // Saturation and coincident update on r3
    chk_a2 = 5'd3;
    issue(3); issue(3); issue(3);
    iss_valid = 1'b1; iss_addr = 5'd3;
    #1 check("sat_stall", iss_stall, 1);
    tick();
    check("sat_hold", iss_stall, 1);
    iss_valid = 1'b0;
    src(2, 5'd3, 32'h33, 32'h500);
    req_valid = 3'b100;
    tick();
    req_valid = 3'b000;
    iss_valid = 1'b1; iss_addr = 5'd3;
    #1 check("co_pre_stall", iss_stall, 0);
    req_valid = 3'b100;
    tick();
    req_valid = 3'b000;
    #1 check("co_after_stall", iss_stall, 0);
    tick();
    check("co_refill_stall", iss_stall, 1);
    iss_valid = 1'b0;
    check("busy_a2_r3", busy_a2, 1);

    // Underflow on r9
    src(2, 5'd9, 32'h99, 32'h900);
    req_valid = 3'b100;
    #1 check("uf_pre", sb_err, 0);
    tick();
    req_valid = 3'b000;
    check("uf_err", sb_err, 1);
    check("uf_regwr", RegWr, 1);
    check("uf_a3", A3, 9);
    chk_a1 = 5'd9;
    tick();
    check("uf_sticky", sb_err, 1);
    check("uf_cnt0", busy_a1, 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
